// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO controller and its read engine.
package fifo_pkg;

    localparam int FIFO_ADDRESSWIDTH = 5;
    localparam int DEPTH             = 1 << FIFO_ADDRESSWIDTH;

    typedef logic [FIFO_ADDRESSWIDTH:0] count_t;

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_READ     = 2'd1,
        RD_WAIT_ACK = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_stall_timer.sv
// Counts consecutive stalled read cycles and flags the cycle the limit is reached.
module fifo_stall_timer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_STALL = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] ONE        = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO       = {CW{1'b0}};

    logic [CW-1:0] count_q, count_d;

    // The current cycle is stall number count_q+1.
    assign expired = stall && (count_q == LAST_STALL);

    // Next stall count: any non-stalled cycle breaks the run.
    always_comb begin
        count_d = count_q;
        if (!stall || expired) begin
            count_d = ZERO;
        end else begin
            count_d = count_q + ONE;
        end
    end

    // Stall count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read engine: turns "read N words" into rd strobes against the FIFO controller.
// Optional stall timeout enabled by defining FIFO_READER_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int ADDRESSWIDTH   = FIFO_ADDRESSWIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDRESSWIDTH:0] burst_len,
    input  logic                  emp,
    input  logic                  rd_en,
    output logic                  rd,
    output logic                  busy,
    output logic                  done,
    output logic [ADDRESSWIDTH:0] ack_count,
    output logic                  err
);

    localparam logic [ADDRESSWIDTH:0] CNT_ZERO = {(ADDRESSWIDTH+1){1'b0}};

    rd_state_t             state_q, state_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDRESSWIDTH:0] len_q, len_d;
    logic [ADDRESSWIDTH:0] remaining_q, remaining_d;
    logic [ADDRESSWIDTH:0] ack_count_q, ack_count_d;

    logic                  accept;
    logic                  timeout;
    logic [ADDRESSWIDTH:0] remaining_after;
    logic [ADDRESSWIDTH:0] ack_total;

    // The controller only takes a word when it has one; rd during emp is a stall.
    assign accept          = rd_q && !emp;
    assign remaining_after = remaining_q - {{ADDRESSWIDTH{1'b0}}, accept};
    assign ack_total       = ack_count_q + {{ADDRESSWIDTH{1'b0}}, rd_en};

`ifdef FIFO_READER_TIMEOUT_EN
    logic stall;

    assign stall = (state_q == RD_READ) && rd_q && emp;

    fifo_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Next-state and next-output logic for the burst FSM and its counters.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        len_d       = len_q;
        remaining_d = remaining_q;
        ack_count_d = ack_count_q;

        case (state_q)
            RD_IDLE: begin
                rd_d   = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    ack_count_d = CNT_ZERO;
                    if (burst_len != CNT_ZERO) begin
                        state_d     = RD_READ;
                        len_d       = burst_len;
                        remaining_d = burst_len;
                        busy_d      = 1'b1;
                        rd_d        = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = RD_IDLE;
                end
            end

            RD_READ: begin
                ack_count_d = ack_total;
                remaining_d = remaining_after;
                rd_d        = (remaining_after != CNT_ZERO);
                if (timeout) begin
                    state_d     = RD_IDLE;
                    rd_d        = 1'b0;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    remaining_d = CNT_ZERO;
                end else if (remaining_after == CNT_ZERO) begin
                    state_d = RD_WAIT_ACK;
                end else begin
                    state_d = RD_READ;
                end
            end

            RD_WAIT_ACK: begin
                rd_d        = 1'b0;
                ack_count_d = ack_total;
                if (ack_total == len_q) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = RD_WAIT_ACK;
                end
            end

            default: begin
                state_d = RD_IDLE;
                rd_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= CNT_ZERO;
            remaining_q <= CNT_ZERO;
            ack_count_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            ack_count_q <= ack_count_d;
        end
    end

    assign rd        = rd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ack_count = ack_count_q;

endmodule
